paint_brush_writer: RTL and testbench
=====================================

PAINT_BRUSH_WRITER -- requirements
Module: paint_brush_writer

Interface
REQ-001 Parameter H_RES, default 640, framebuffer width in pixels.
REQ-002 Parameter V_RES, default 480, framebuffer height in pixels.
REQ-003 Parameter BRUSH, default 3, brush side in pixels; odd, 1..7; radius R=(BRUSH-1)/2.
REQ-004 Parameter DATA_W, default 12, pixel color width.
REQ-005 Parameter BG_COLOR, default 0, erase color.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 pos_x  in  16  absolute cursor X, unsigned, 0..H_RES-1.
REQ-009 pos_y  in  16  absolute cursor Y, unsigned, 0..V_RES-1.
REQ-010 mouse_left  in  1  paint button level.
REQ-011 mouse_right  in  1  erase button level.
REQ-012 pos_valid  in  1  one-cycle pulse; pos_x/pos_y/buttons valid this cycle.
REQ-013 color  in  DATA_W  current paint color, sampled with pos_valid.
REQ-014 wr_en  out  1  framebuffer write request.
REQ-015 wr_addr  out  19  linear pixel address y*H_RES+x.
REQ-016 wr_data  out  DATA_W  pixel value.
REQ-017 wr_ready  in  1  framebuffer accepts the write when wr_en&&wr_ready.
REQ-018 busy  out  1  high while a stamp is in progress or pending.

Function
REQ-019 States: IDLE, STAMP; a stamp is the BRUSH x BRUSH square centered on the latched (x,y).
REQ-020 In IDLE, a pos_valid with mouse_left or mouse_right high latches x, y, and the stamp color, then enters STAMP on the next cycle; pos_valid with both buttons low is ignored.
REQ-021 Stamp color is color when mouse_left is high (left wins if both are pressed); otherwise it is BG_COLOR.
REQ-022 STAMP scans offsets dy=-R..+R (outer loop) and dx=-R..+R (inner loop) in raster order.
REQ-023 For an in-bounds offset (0<=x+dx<H_RES, 0<=y+dy<V_RES), wr_en is high and wr_addr/wr_data are held stable until wr_ready is high.
REQ-024 The scan advances on the cycle wr_en&&wr_ready; wr_en is never dropped before acceptance.
REQ-025 An out-of-bounds offset consumes exactly one cycle with wr_en low; no address is computed from negative or overflowing coordinates.
REQ-026 The first write is presented on the cycle after the accepting pos_valid, so latency is 1 cycle.
REQ-027 An unstalled, unclipped stamp takes BRUSH*BRUSH cycles.
REQ-028 A pos_valid that arrives during STAMP is stored in a one-deep pending slot holding x, y, color and mode; a later pos_valid overwrites the slot, so the latest event wins.
REQ-029 At stamp end, if the pending slot is valid, the next cycle starts STAMP from it (no IDLE cycle) and the slot is cleared; otherwise the block returns to IDLE.
REQ-030 A pos_valid on the final accepted cycle of a stamp is captured into the pending slot and is not lost.
REQ-031 wr_addr is computed as y*H_RES+x with at least 19 bits and no truncation for all in-bounds pixels (max 307199 at defaults).
REQ-032 busy = (state==STAMP) || pending_valid.

Reset
REQ-033 While rst is high at a clock edge: state=IDLE, pending slot cleared, wr_en=0, wr_addr=0, wr_data=0, busy=0.
REQ-034 A reset mid-stamp aborts the stamp immediately and discards the pending slot; no write is emitted on the cycle after reset deasserts.

Structure
REQ-035 H_RES/V_RES defaults, framebuffer address width (19), and pixel width belong in the shared paint package, common to integrator and framebuffer.
REQ-036 One sub-module is natural: brush_scan_counter, which generates the dx/dy offsets, the last-offset flag, and an advance enable; the address multiply uses constant shift-add.

Verification
REQ-037 Center stamp: pos (100,50), left=1, color=0xF00, wr_ready=1 -> 9 writes on consecutive cycles, addresses 31459..31461, 32099..32101, 32739..32741, data 0xF00, first write 1 cycle after pos_valid.
REQ-038 Corner clip: pos (0,0), left=1 -> writes only at addresses 0, 1, 640, 641; 5 cycles with wr_en=0; stamp takes 9 cycles total.
REQ-039 Erase and priority: right=1 at (639,479) -> 4 writes with data BG_COLOR, last address 307199; then left=1 and right=1 -> data equals color.
REQ-040 Backpressure: wr_ready low for 3 cycles on the 2nd write -> wr_addr/wr_data are held stable, no write is skipped or duplicated, and the stamp takes 12 cycles.
REQ-041 Pending: 3 pos_valid pulses during one stamp ((10,10), (20,20), (30,30)) -> the second stamp is centered at (30,30) and starts the cycle after the first ends; busy falls after it.
REQ-042 Reset mid-stamp: rst on the 4th write with a pending event -> wr_en=0 and busy=0 after reset, and no further writes until a new pos_valid.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared paint framebuffer constants: resolution defaults, address and pixel widths.
// Common to the brush writer, the integrator and the framebuffer.
package paint_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int ADDR_W    = 19;
    localparam int PIX_W     = 12;
    localparam int COORD_W   = 16;
    localparam int OFF_W     = 4;

    typedef enum logic {
        S_IDLE,
        S_STAMP
    } state_t;

    // Linear framebuffer address; hres is a constant so the multiply reduces to shift-add.
    function automatic logic [ADDR_W-1:0] lin_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int unsigned        hres
    );
        return ADDR_W'(y) * ADDR_W'(hres) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/paint_brush_writer_scan.sv
// Brush offset generator: walks dy then dx over -R..+R in raster order.
// Advances on an accepted write or immediately on a clipped offset.
module brush_scan_counter
    import paint_pkg::*;
#(
    parameter int BRUSH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_active,
    input  logic                    i_inb,
    input  logic                    i_ready,
    output logic signed [OFF_W-1:0] o_dx,
    output logic signed [OFF_W-1:0] o_dy,
    output logic                    o_last,
    output logic                    o_adv
);

    localparam int R = (BRUSH - 1) / 2;
    localparam logic signed [OFF_W-1:0] RP = OFF_W'(R);
    localparam logic signed [OFF_W-1:0] RN = -RP;

    logic signed [OFF_W-1:0] r_dx;
    logic signed [OFF_W-1:0] r_dy;

    always_comb begin
        o_dx   = r_dx;
        o_dy   = r_dy;
        o_last = (r_dx == RP) && (r_dy == RP);
        o_adv  = i_active && (!i_inb || i_ready);
    end

    // Wrapping to -R on the last offset lets a queued stamp start with no gap.
    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_dx <= RN;
            r_dy <= RN;
        end else if (o_adv) begin
            if (o_last) begin
                r_dx <= RN;
                r_dy <= RN;
            end else if (r_dx == RP) begin
                r_dx <= RN;
                r_dy <= r_dy + 4'sd1;
            end else begin
                r_dx <= r_dx + 4'sd1;
            end
        end
    end

endmodule

// File: rtl/paint_brush_writer.sv
// Brush stamper: turns cursor events into BRUSH x BRUSH framebuffer writes,
// clipping at the edges and holding one pending event while a stamp runs.
module paint_brush_writer
    import paint_pkg::*;
#(
    parameter int                H_RES    = H_RES_DEF,
    parameter int                V_RES    = V_RES_DEF,
    parameter int                BRUSH    = 3,
    parameter int                DATA_W   = PIX_W,
    parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         pos_x,
    input  logic [15:0]         pos_y,
    input  logic                mouse_left,
    input  logic                mouse_right,
    input  logic                pos_valid,
    input  logic [DATA_W-1:0]   color,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    input  logic                wr_ready,
    output logic                busy
);

    state_t              r_state, w_state_n;
    logic [15:0]         r_x, r_y, w_x_n, w_y_n;
    logic [DATA_W-1:0]   r_c, w_c_n;
    logic                r_pv, w_pv_n;
    logic [15:0]         r_px, r_py, w_px_n, w_py_n;
    logic [DATA_W-1:0]   r_pc, w_pc_n;

    logic                    w_ev;
    logic [DATA_W-1:0]       w_ev_c;
    logic                    w_active;
    logic signed [OFF_W-1:0] w_dx, w_dy;
    logic                    w_last, w_adv;
    logic signed [16:0]      w_sx, w_sy;
    logic                    w_xin, w_yin, w_pix_in, w_inb;

    assign w_ev     = pos_valid && (mouse_left || mouse_right);
    assign w_ev_c   = mouse_left ? color : BG_COLOR;
    assign w_active = (r_state == S_STAMP);

    // 17-bit signed sums so negative or overflowing coordinates are caught before addressing.
    assign w_sx     = $signed({1'b0, r_x}) + 17'(w_dx);
    assign w_sy     = $signed({1'b0, r_y}) + 17'(w_dy);
    assign w_xin    = !w_sx[16] && (w_sx[15:0] < 16'(H_RES));
    assign w_yin    = !w_sy[16] && (w_sy[15:0] < 16'(V_RES));
    assign w_pix_in = w_xin && w_yin;
    assign w_inb    = w_active && w_pix_in;

    brush_scan_counter #(
        .BRUSH (BRUSH)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .i_active (w_active),
        .i_inb    (w_pix_in),
        .i_ready  (wr_ready),
        .o_dx     (w_dx),
        .o_dy     (w_dy),
        .o_last   (w_last),
        .o_adv    (w_adv)
    );

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_c_n     = r_c;
        w_pv_n    = r_pv;
        w_px_n    = r_px;
        w_py_n    = r_py;
        w_pc_n    = r_pc;
        unique case (r_state)
            S_IDLE: begin
                if (w_ev) begin
                    w_state_n = S_STAMP;
                    w_x_n     = pos_x;
                    w_y_n     = pos_y;
                    w_c_n     = w_ev_c;
                end
            end
            S_STAMP: begin
                if (w_adv && w_last) begin
                    // An event on the closing cycle is newer than the slot, so it wins.
                    if (w_ev) begin
                        w_x_n  = pos_x;
                        w_y_n  = pos_y;
                        w_c_n  = w_ev_c;
                        w_pv_n = 1'b0;
                    end else if (r_pv) begin
                        w_x_n  = r_px;
                        w_y_n  = r_py;
                        w_c_n  = r_pc;
                        w_pv_n = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else if (w_ev) begin
                    w_pv_n = 1'b1;
                    w_px_n = pos_x;
                    w_py_n = pos_y;
                    w_pc_n = w_ev_c;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_c     <= '0;
            r_pv    <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_c     <= w_c_n;
            r_pv    <= w_pv_n;
            r_px    <= w_px_n;
            r_py    <= w_py_n;
            r_pc    <= w_pc_n;
        end
    end

    always_comb begin
        wr_en   = w_inb;
        wr_addr = w_inb ? lin_addr(w_sx[15:0], w_sy[15:0], H_RES) : '0;
        wr_data = w_inb ? r_c : '0;
        busy    = w_active || r_pv;
    end

endmodule

// File: tb/tb_paint_brush_writer.sv
// Bench for paint_brush_writer: slot-queue reference model checked every cycle,
// directed edge cases with literal expectations, then randomized traffic.
module tb_paint_brush_writer;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int B  = 3;
    localparam int R  = (B - 1) / 2;
    localparam int DW = 12;
    localparam int BG = 0;

    logic          clk;
    logic          rst;
    logic [15:0]   pos_x, pos_y;
    logic          mouse_left, mouse_right, pos_valid;
    logic [DW-1:0] color;
    logic          wr_en;
    logic [18:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          busy;

    paint_brush_writer #(
        .H_RES    (H),
        .V_RES    (V),
        .BRUSH    (B),
        .DATA_W   (DW),
        .BG_COLOR (DW'(BG))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .mouse_left  (mouse_left),
        .mouse_right (mouse_right),
        .pos_valid   (pos_valid),
        .color       (color),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wr;
        int addr;
        int data;
    } slot_t;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wlog_t;

    slot_t mq[$];
    bit    m_pv;
    int    m_px, m_py, m_pc;
    wlog_t wl[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    n_busy = 0;
    int    n_gap = 0;
    bit    chk_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One stamp = BRUSH*BRUSH cycle slots; clipped pixels are idle slots.
    function automatic void build(input int x, input int y, input int c);
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                slot_t s;
                int xx = x + dx;
                int yy = y + dy;
                s.wr   = (xx >= 0 && xx < H && yy >= 0 && yy < V);
                s.addr = s.wr ? yy * H + xx : 0;
                s.data = c;
                mq.push_back(s);
            end
        end
    endfunction

    always @(negedge clk) begin : mon
        bit e_en;
        bit ev;
        int ec;
        if (chk_on) begin
            e_en = (mq.size() > 0) && mq[0].wr;
            chk("wr_en", 32'(wr_en), 32'(e_en));
            chk("busy", 32'(busy), 32'((mq.size() > 0) || m_pv));
            if (e_en) begin
                chk("wr_addr", 32'(wr_addr), mq[0].addr);
                chk("wr_data", 32'(wr_data), mq[0].data);
            end
            if (wr_en && wr_ready)
                wl.push_back('{int'(wr_addr), int'(wr_data), cyc});
            if (busy) n_busy++;
            if (busy && !wr_en) n_gap++;
        end
        ev = pos_valid && (mouse_left || mouse_right);
        ec = mouse_left ? int'(color) : BG;
        if (rst) begin
            mq.delete();
            m_pv = 0;
        end else if (mq.size() == 0) begin
            if (ev) build(int'(pos_x), int'(pos_y), ec);
        end else begin
            if (!mq[0].wr || wr_ready) void'(mq.pop_front());
            if (mq.size() == 0) begin
                if (ev) begin
                    build(int'(pos_x), int'(pos_y), ec);
                    m_pv = 0;
                end else if (m_pv) begin
                    build(m_px, m_py, m_pc);
                    m_pv = 0;
                end
            end else if (ev) begin
                m_pv = 1;
                m_px = int'(pos_x);
                m_py = int'(pos_y);
                m_pc = ec;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int x, input int y, input bit l, input bit r, input int c);
        pos_x       = 16'(x);
        pos_y       = 16'(y);
        mouse_left  = l;
        mouse_right = r;
        color       = DW'(c);
        pos_valid   = 1'b1;
        step();
        pos_valid   = 1'b0;
        mouse_left  = 1'b0;
        mouse_right = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || m_pv || busy) && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < 300), 1);
    endtask

    task automatic clr();
        wl.delete();
        n_busy = 0;
        n_gap  = 0;
    endtask

    initial begin
        int pc;
        int ea[9];
        rst = 1'b1;
        pos_x = '0;
        pos_y = '0;
        mouse_left = 1'b0;
        mouse_right = 1'b0;
        pos_valid = 1'b0;
        color = '0;
        wr_ready = 1'b1;
        step();
        chk_on = 1;
        step();
        rst = 1'b0;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        step();

        // center stamp
        clr();
        pc = cyc;
        pulse(100, 50, 1, 0, 'hF00);
        drain();
        ea = '{31459, 31460, 31461, 32099, 32100, 32101, 32739, 32740, 32741};
        chk("center_count", wl.size(), 9);
        if (wl.size() == 9) begin
            chk("center_latency", wl[0].cyc, pc + 1);
            chk("center_span", wl[8].cyc - wl[0].cyc, 8);
            for (int i = 0; i < 9; i++) begin
                chk("center_addr", wl[i].addr, ea[i]);
                chk("center_data", wl[i].data, 'hF00);
            end
        end

        // corner clip
        clr();
        pulse(0, 0, 1, 0, 'h0A5);
        drain();
        chk("corner_count", wl.size(), 4);
        if (wl.size() == 4) begin
            chk("corner_a0", wl[0].addr, 0);
            chk("corner_a1", wl[1].addr, 1);
            chk("corner_a2", wl[2].addr, 640);
            chk("corner_a3", wl[3].addr, 641);
        end
        chk("corner_cycles", n_busy, 9);
        chk("corner_gaps", n_gap, 5);

        // erase at far corner, then both buttons
        clr();
        pulse(639, 479, 0, 1, 'h777);
        drain();
        chk("erase_count", wl.size(), 4);
        if (wl.size() == 4) begin
            chk("erase_last", wl[3].addr, 307199);
            for (int i = 0; i < 4; i++) chk("erase_data", wl[i].data, BG);
        end
        clr();
        pulse(5, 5, 1, 1, 'h0AB);
        drain();
        chk("both_count", wl.size(), 9);
        foreach (wl[i]) chk("both_data", wl[i].data, 'h0AB);

        // backpressure on the 2nd write
        clr();
        pulse(200, 100, 1, 0, 'h123);
        step();
        wr_ready = 1'b0;
        step();
        step();
        step();
        wr_ready = 1'b1;
        drain();
        chk("bp_count", wl.size(), 9);
        if (wl.size() == 9)
            for (int i = 0; i < 9; i++)
                chk("bp_addr", wl[i].addr, (99 + i / 3) * H + 199 + i % 3);
        chk("bp_cycles", n_busy, 12);

        // pending slot, latest event wins
        clr();
        pulse(300, 300, 1, 0, 'h0F0);
        pulse(10, 10, 1, 0, 'h111);
        pulse(20, 20, 1, 0, 'h222);
        pulse(30, 30, 1, 0, 'h333);
        drain();
        chk("pend_count", wl.size(), 18);
        if (wl.size() == 18) begin
            chk("pend_first_end", wl[8].addr, 192941);
            chk("pend_start", wl[9].addr, 18589);
            chk("pend_back2back", wl[9].cyc, wl[8].cyc + 1);
            chk("pend_end", wl[17].addr, 19871);
            chk("pend_data", wl[17].data, 'h333);
        end
        chk("pend_cycles", n_busy, 18);
        chk("pend_busy_low", 32'(busy), 0);

        // reset mid-stamp with a pending event
        clr();
        pulse(400, 200, 1, 0, 'h456);
        pulse(50, 50, 1, 0, 'h789);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_wr_en", 32'(wr_en), 0);
        chk("rstmid_busy", 32'(busy), 0);
        repeat (6) step();
        chk("rstmid_writes", wl.size(), 4);
        chk("rstmid_busy_after", 32'(busy), 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            wr_ready  = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) == 0);
            pos_valid = ($urandom_range(0, 5) == 0);
            mouse_left  = $urandom_range(0, 1);
            mouse_right = $urandom_range(0, 1);
            color = DW'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                pos_x = ($urandom_range(0, 1) != 0) ? 16'(H - 1) : 16'd0;
                pos_y = ($urandom_range(0, 1) != 0) ? 16'(V - 1) : 16'd0;
            end else begin
                pos_x = 16'($urandom_range(0, H - 1));
                pos_y = 16'($urandom_range(0, V - 1));
            end
            step();
        end
        rst = 1'b0;
        pos_valid = 1'b0;
        mouse_left = 1'b0;
        mouse_right = 1'b0;
        wr_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
